// File: rtl/jump_pkg.sv
// ---------------------------------------------------------------------------
// jump_pkg
// Shared definitions for the jump initiator: FSM state encoding, datapath
// widths, LFSR tap mask and small helper functions.
// ---------------------------------------------------------------------------
package jump_pkg;

  localparam int POS_W   = 3;
  localparam int DELTA_W = 4;
  localparam int LFSR_W  = 8;

  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ROLL     = 2'd1,
    ISSUE    = 2'd2,
    COOLDOWN = 2'd3
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // A zero jump would be a wasted turn, so it is promoted to one step.
  function automatic logic [DELTA_W-1:0] nonzero_delta(input logic [DELTA_W-1:0] d);
    return (d == '0) ? DELTA_W'(1) : d;
  endfunction

endpackage

// File: rtl/jump_sequencer_if.sv
// ---------------------------------------------------------------------------
// jump_sequencer_if
// The delta/enable_jump jump interface between the initiator (master) and
// the board-position counter (slave).
//   delta       : jump distance, stable for the whole strobe window
//   enable_jump : one-cycle strobe; the receiver adds delta on this edge
// ---------------------------------------------------------------------------
interface jump_sequencer_if;
  import jump_pkg::*;

  logic [DELTA_W-1:0] delta;
  logic               enable_jump;

  modport master (output delta, output enable_jump);
  modport slave  (input  delta, input  enable_jump);
endinterface

// File: rtl/roll_sync_edge.sv
// ---------------------------------------------------------------------------
// roll_sync_edge
// Two-flop synchroniser for the asynchronous roll button followed by a
// rising-edge detector.
//   sys_clk     : system clock
//   clr_n       : asynchronous active-low reset
//   roll_i      : raw asynchronous button level
//   roll_edge_o : one-cycle pulse per synchronised rising edge
// ---------------------------------------------------------------------------
module roll_sync_edge (
  input  logic sys_clk,
  input  logic clr_n,
  input  logic roll_i,
  output logic roll_edge_o
);

  // [0] and [1] are the synchroniser stages, [2] holds the previous level.
  logic [2:0] sync_q;

  // NOTE: sequential state uses <= so every flop samples the pre-edge
  // value of its neighbour; = here would collapse the chain into one flop.
  always_ff @(posedge sys_clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], roll_i};
    end
  end

  assign roll_edge_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/jump_sequencer.sv
// ---------------------------------------------------------------------------
// jump_sequencer
// Initiator side of the jump interface. A rising edge on roll_req becomes a
// non-zero jump distance and a single-cycle enable_jump strobe, followed by
// a fixed cooldown. A shadow copy of the board position is kept with the
// same modulo-8 arithmetic as the position counter.
//
// Parameters:
//   COOLDOWN_CYC : cycles spent in COOLDOWN after each strobe (1..255)
//   LFSR_SEED    : non-zero LFSR reset value
//
// Ports:
//   sys_clk     : system clock, rising edge
//   clr_n       : asynchronous active-low reset
//   roll_req    : asynchronous button level; a rising edge requests a jump
//   fixed_delta : distance source (only when FIXED_DELTA_EN is defined)
//   jmp         : master side of jump_sequencer_if (delta, enable_jump)
//   busy        : high whenever the FSM is not in IDLE
//   shadow_pos  : mirror of the board position, modulo 8
//   jump_count  : strobes issued, saturating at 255
//
// Build option: FIXED_DELTA_EN -- when defined, ROLL captures fixed_delta
// instead of the LFSR nibble (the LFSR keeps running).
// ---------------------------------------------------------------------------
module jump_sequencer
  import jump_pkg::*;
#(
  parameter int                COOLDOWN_CYC = 8,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = 8'hA5
) (
  input  logic               sys_clk,
  input  logic               clr_n,
  input  logic               roll_req,
`ifdef FIXED_DELTA_EN
  input  logic [DELTA_W-1:0] fixed_delta,
`endif
  jump_sequencer_if.master   jmp,
  output logic               busy,
  output logic [POS_W-1:0]   shadow_pos,
  output logic [7:0]         jump_count
);

  localparam logic [7:0] CD_LOAD = 8'(COOLDOWN_CYC - 1);

  logic               roll_edge;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [DELTA_W-1:0] raw_delta;

  state_e             state_q;
  logic [DELTA_W-1:0] delta_q;
  logic               enable_q;
  logic               busy_q;
  logic [POS_W-1:0]   shadow_q;
  logic [7:0]         count_q;
  logic [7:0]         cd_q;

  roll_sync_edge u_sync (
    .sys_clk     (sys_clk),
    .clr_n       (clr_n),
    .roll_i      (roll_req),
    .roll_edge_o (roll_edge)
  );

  // Free-running in every state so the distance depends on when the
  // player presses, not just how many times.
  // NOTE: combinational blocks assign every output on every path; a
  // missing assignment would infer a latch.
  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge sys_clk or negedge clr_n) begin
    if (!clr_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

`ifdef FIXED_DELTA_EN
  assign raw_delta = fixed_delta;
`else
  assign raw_delta = lfsr_q[DELTA_W-1:0];
`endif

  // All FSM outputs are registered here so the strobe and distance leave
  // the block glitch-free and drop asynchronously with clr_n.
  always_ff @(posedge sys_clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      delta_q  <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      shadow_q <= '0;
      count_q  <= '0;
      cd_q     <= '0;
    end else begin
      enable_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Edges seen in any other state are intentionally dropped.
          if (roll_edge) begin
            state_q <= ROLL;
            busy_q  <= 1'b1;
          end
        end
        ROLL: begin
          delta_q  <= nonzero_delta(raw_delta);
          enable_q <= 1'b1;
          state_q  <= ISSUE;
        end
        ISSUE: begin
          // Only the low bits matter: the board wraps modulo 8, so a
          // distance of 8 leaves the position unchanged.
          shadow_q <= shadow_q + delta_q[POS_W-1:0];
          if (count_q != 8'hFF) begin
            count_q <= count_q + 8'd1;
          end
          cd_q    <= CD_LOAD;
          state_q <= COOLDOWN;
        end
        COOLDOWN: begin
          if (cd_q == 8'd0) begin
            state_q <= IDLE;
            delta_q <= '0;
            busy_q  <= 1'b0;
          end else begin
            cd_q <= cd_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign jmp.delta       = delta_q;
  assign jmp.enable_jump = enable_q;
  assign busy            = busy_q;
  assign shadow_pos      = shadow_q;
  assign jump_count      = count_q;

endmodule

// File: tb/tb_jump_sequencer.sv
// ---------------------------------------------------------------------------
// tb_jump_sequencer
// Self-checking bench for jump_sequencer. A cycle-level reference model
// predicts every output from the behavioural rules: request rise -> ROLL
// three edges later if idle, strobe one edge after that, then cooldown.
// ---------------------------------------------------------------------------
module tb_jump_sequencer;

  localparam int         CD   = 8;
  localparam logic [7:0] SEED = 8'hA5;

  logic       sys_clk = 1'b0;
  logic       clr_n   = 1'b0;
  logic       roll_req = 1'b0;
  logic       busy;
  logic [2:0] shadow_pos;
  logic [7:0] jump_count;
`ifdef FIXED_DELTA_EN
  logic [3:0] fixed_delta = 4'd0;
`endif

  jump_sequencer_if jif ();

  jump_sequencer #(
    .COOLDOWN_CYC (CD),
    .LFSR_SEED    (SEED)
  ) dut (
    .sys_clk     (sys_clk),
    .clr_n       (clr_n),
    .roll_req    (roll_req),
`ifdef FIXED_DELTA_EN
    .fixed_delta (fixed_delta),
`endif
    .jmp         (jif),
    .busy        (busy),
    .shadow_pos  (shadow_pos),
    .jump_count  (jump_count)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Reference model state. cyc counts rising edges since reset release.
  int         cyc;
  int         acc_at;
  int         strobe_at;
  int         free_at;
  int         m_shadow;
  int         m_accepts;
  logic [7:0] m_count;
  logic [3:0] m_delta;
  logic [7:0] m_lfsr;
  bit         cur_req;
  int         detect_q[$];
  int         strobes;
  int         last_strobe;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One step of x^8+x^6+x^5+x^4+1, taps derived from the exponents.
  function automatic logic [7:0] poly_step(input logic [7:0] s);
    int         exps[4] = '{8, 6, 5, 4};
    logic [7:0] mask = '0;
    logic       out_bit;
    foreach (exps[i]) mask[exps[i]-1] = 1'b1;
    out_bit = s[0];
    s = s >> 1;
    if (out_bit) s = s ^ mask;
    return s;
  endfunction

  task automatic model_reset();
    cyc         = 0;
    acc_at      = -10;
    strobe_at   = -10;
    free_at     = 0;
    m_shadow    = 0;
    m_count     = 8'd0;
    m_delta     = 4'd0;
    m_lfsr      = SEED;
    cur_req     = 1'b0;
    last_strobe = 0;
    detect_q.delete();
  endtask

  // Advance one clock, update the model, compare at the falling edge,
  // then drive the next request level.
  task automatic tick(input bit next_req);
    @(posedge sys_clk);
    cyc++;
    if (cyc == strobe_at + 1) begin
      m_shadow = (m_shadow + int'(m_delta)) % 8;
      if (m_count != 8'd255) m_count = m_count + 8'd1;
    end
    m_lfsr = poly_step(m_lfsr);
    while (detect_q.size() > 0 && detect_q[0] == cyc) begin
      void'(detect_q.pop_front());
      if (cyc - 1 >= free_at) begin
        acc_at    = cyc;
        strobe_at = cyc + 1;
        free_at   = cyc + 2 + CD;
        m_accepts++;
`ifdef FIXED_DELTA_EN
        m_delta = fixed_delta;
`else
        m_delta = m_lfsr[3:0];
`endif
        if (m_delta == 4'd0) m_delta = 4'd1;
      end
    end
    @(negedge sys_clk);
    check("enable_jump", {31'd0, jif.enable_jump}, {31'd0, cyc == strobe_at});
    check("delta", {28'd0, jif.delta},
          (cyc >= strobe_at && cyc < free_at) ? {28'd0, m_delta} : 32'd0);
    check("busy", {31'd0, busy}, {31'd0, (cyc >= acc_at && cyc < free_at)});
    check("shadow_pos", {29'd0, shadow_pos}, 32'(m_shadow));
    check("jump_count", {24'd0, jump_count}, {24'd0, m_count});
    if (jif.enable_jump === 1'b1) begin
      if (last_strobe > 0) check("strobe_gap", {31'd0, (cyc - last_strobe) >= CD + 2}, 32'd1);
      check("delta_nonzero", {31'd0, jif.delta != 4'd0}, 32'd1);
      strobes++;
      last_strobe = cyc;
    end
    roll_req = next_req;
    if (next_req && !cur_req) detect_q.push_back(cyc + 3);
    cur_req = next_req;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((detect_q.size() != 0 || cyc < free_at) && n < 200) begin
      tick(1'b0);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: observed timeout expected idle within 200 cycles");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},     {31'd0, jif.enable_jump}, 32'd0);
    check({tag, "_delta"},  {28'd0, jif.delta},       32'd0);
    check({tag, "_busy"},   {31'd0, busy},            32'd0);
    check({tag, "_shadow"}, {29'd0, shadow_pos},      32'd0);
    check({tag, "_count"},  {24'd0, jump_count},      32'd0);
  endtask

  initial begin
    int acc_before;
    int str_before;
    int n;

    model_reset();
    m_accepts = 0;
    strobes   = 0;

    // Reset held: all outputs at reset values.
    repeat (3) @(posedge sys_clk);
    #1;
    check_reset_outputs("rst");
    @(negedge sys_clk);
    clr_n = 1'b1;

    // Idle: nothing moves without a request.
    repeat (20) tick(1'b0);

`ifdef FIXED_DELTA_EN
    fixed_delta = 4'd5;
    tick(1'b1); tick(1'b0); wait_idle();
    check("fd_shadow_5", {29'd0, shadow_pos}, 32'd5);
    check("fd_count_1", {24'd0, jump_count}, 32'd1);
    fixed_delta = 4'd6;
    tick(1'b1); tick(1'b0); wait_idle();
    check("fd_shadow_wrap", {29'd0, shadow_pos}, 32'd3);
    fixed_delta = 4'd0;
    tick(1'b1); tick(1'b0); wait_idle();
    check("fd_zero_as_one", {29'd0, shadow_pos}, 32'd4);
`endif

    // First LFSR roll, then a held level that must yield one request.
    tick(1'b1); tick(1'b0); wait_idle();
    repeat (15) tick(1'b1);
    tick(1'b0); wait_idle();

    // Pulses every 2 cycles: only edges seen in IDLE become strobes.
    acc_before = m_accepts;
    str_before = strobes;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1);
      tick(1'b0);
    end
    wait_idle();
    check("pulse_strobes", 32'(strobes - str_before), 32'(m_accepts - acc_before));

    // Reset asserted during the ISSUE cycle.
    tick(1'b1); tick(1'b0);
    n = 0;
    while (cyc != strobe_at && n < 20) begin
      tick(1'b0);
      n++;
    end
    check("issue_reached", {31'd0, jif.enable_jump}, 32'd1);
    clr_n    = 1'b0;
    roll_req = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    clr_n = 1'b1;
    model_reset();
    str_before = strobes;
    repeat (30) tick(1'b0);
    check("no_replay", 32'(strobes - str_before), 32'd0);

    // 300 randomly timed rolls: count saturates, shadow tracks the sum.
    str_before = strobes;
    for (int r = 0; r < 300; r++) begin
      repeat ($urandom_range(1, 3)) tick(1'b1);
      wait_idle();
      repeat ($urandom_range(0, 2)) tick(1'b0);
    end
    check("roll_total", 32'(strobes - str_before), 32'd300);
    check("count_saturated", {24'd0, jump_count}, 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
